dmem_ctrl: RTL and testbench

Parametrised data-memory controller replacing the bare single-cycle data RAM hookup between the `mips` core and data storage. It owns a word-organised RAM array of configurable depth and access latency, and adds byte/halfword stores via lane enables, sign/zero-extending sub-word loads, and an alignment check. A req/ready handshake lets the core stall on multi-cycle accesses.

---
 rtl/dmem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores to a DEPTH-word RAM; define DMEM_ALIGN_CHECK_EN for misalignment errors.
// Ready pulses RD_LAT+1 cycles after accept (1 for illegal); the core holds req and stalls on req & ~ready.
module dmem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LO_W  = IDX_W + 2;
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sext_q, sext_d;
  logic [LO_W-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       lane_en;
  logic [31:0]      wr_word, rd_word, load_val;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             mem_commit, illegal;
  logic             unused_addr;

  // Upper address bits alias by design.
  assign unused_addr = ^addr;

  assign idx     = addr_q[LO_W-1:2];
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  // Offsets are masked to the access size, so unaligned halves/words snap down when unchecked.
  always_comb begin
    case (size_q)
      2'b00: begin
        off      = addr_q[1:0];
        lane_en  = 4'b0001 << addr_q[1:0];
        wr_word  = {4{wdata_q[7:0]}};
        load_val = sext_q ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
      end
      2'b01: begin
        off      = {addr_q[1], 1'b0};
        lane_en  = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{wdata_q[15:0]}};
        load_val = sext_q ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
      end
      default: begin
        off      = 2'b00;
        lane_en  = 4'b1111;
        wr_word  = wdata_q;
        load_val = rd_word;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    case (size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = addr[0];
      2'b10:   illegal = |addr[1:0];
      default: illegal = 1'b1;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    mem_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sext;
          addr_d  = addr[LO_W-1:0];
          wdata_d = wdata;
          if (illegal) begin
            state_d = S_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          mem_commit = we_q;
          if (!we_q) rdata_d = load_val;
          state_d = S_RESP;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Gating on rst drops a store whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (rst && mem_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[idx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed plan cases plus random traffic against a byte-array reference model.
module tb_dmem_ctrl;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst, req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err;

  int total = 0;
  int bad   = 0;

  byte unsigned mb [DEPTH*4];
  logic [31:0]  last_rd;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(DEPTH), .RD_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  // Reference: memory as little-endian bytes; rdata holds the last load result.
  function automatic void model_op(input logic w, input logic [1:0] sz, input logic sx,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] exp_rd, output logic exp_err);
    int n;
    int base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'd3 || (a % n) != 0) exp_err = 1'b1;
`endif
    base = int'(a % (DEPTH*4));
    base = base - (base % n);
    exp_rd = last_rd;
    if (exp_err) return;
    if (w) begin
      for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base+i];
      if (n < 4 && sx && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      last_rd = v;
      exp_rd  = v;
    end
  endfunction

  task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    lat = 0; rd = 32'd0; er = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        rd = rdata;
        er = err;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10; wdata = 32'd0;
    repeat (2) begin
      @(negedge clk);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b exp=0", ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got=%b exp=0", err); end
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got=%h exp=0", rdata); end
    end
    req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_idle_ready: got=%b exp=0", ready); end
    last_rd = 32'd0;
  endtask

  task automatic init_mem();
    logic [31:0] rd, exp_rd, wd;
    logic er, exp_er;
    int lat;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      run_op(1'b1, 2'd2, 1'b0, 32'(i*4), wd, rd, er, lat);
      model_op(1'b1, 2'd2, 1'b0, 32'(i*4), wd, exp_rd, exp_er);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, exp_rd, exp_er);
    total++; if (lat != LAT+1) begin bad++; $display("FAIL sw_latency: got=%0d exp=%0d", lat, LAT+1); end
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL sw_single_pulse: got=%b exp=0", ready); end
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_10: got=%h exp=deadbeef", rd); end
    total++; if (lat != LAT+1) begin bad++; $display("FAIL lw_latency: got=%0d exp=%0d", lat, LAT+1); end
    run_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, rd, er, lat);
    model_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, exp_rd, exp_er);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL sb_merge: got=%h exp=80adbeef", rd); end
    run_op(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_13: got=%h exp=ffffff80", rd); end
    run_op(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_13: got=%h exp=00000080", rd); end
    run_op(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'hFFFF80AD) begin bad++; $display("FAIL lh_12: got=%h exp=ffff80ad", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    run_op(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, exp_rd, exp_er);
`ifdef DMEM_ALIGN_CHECK_EN
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_err: got=%b exp=1", er); end
    total++; if (lat != 1) begin bad++; $display("FAIL mis_latency: got=%0d exp=1", lat); end
    total++; if (rd !== 32'hFFFF80AD) begin bad++; $display("FAIL mis_rdata_hold: got=%h exp=ffff80ad", rd); end
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL mis_untouched: got=%h exp=80adbeef", rd); end
`else
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_err: got=%b exp=0", er); end
    total++; if (lat != LAT+1) begin bad++; $display("FAIL mis_latency: got=%0d exp=%0d", lat, LAT+1); end
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL mis_rdata: got=%h exp=80adbeef", rd); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_wait_ready: got=%b exp=0", ready); end
    @(negedge clk);
    rst = 1'b1;
    last_rd = 32'd0;
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata_clr: got=%h exp=0", rdata); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got=%b exp=0", ready); end
    run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, exp_rd, exp_er);
    total++; if (rd !== exp_rd) begin bad++; $display("FAIL mid_store_dropped: got=%h exp=%h", rd, exp_rd); end
    total++; if (lat != LAT+1) begin bad++; $display("FAIL mid_idle_latency: got=%0d exp=%0d", lat, LAT+1); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    run_op(1'b1, 2'd2, 1'b0, 32'h1010, 32'hCAFEF00D, rd, er, lat);
    model_op(1'b1, 2'd2, 1'b0, 32'h1010, 32'hCAFEF00D, exp_rd, exp_er);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, exp_rd, exp_er);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap: got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, a, wd;
    logic er, exp_er, w, sx;
    logic [1:0] sz;
    int lat;
    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      wd = $urandom;
      run_op(w, sz, sx, a, wd, rd, er, lat);
      model_op(w, sz, sx, a, wd, exp_rd, exp_er);
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d]: got=%h exp=%h addr=%h size=%0d we=%b", i, rd, exp_rd, a, sz, w); end
      total++; if (er !== exp_er) begin bad++; $display("FAIL rand_err[%0d]: got=%b exp=%b", i, er, exp_er); end
      total++; if (lat != (exp_er ? 1 : LAT+1)) begin bad++; $display("FAIL rand_latency[%0d]: got=%0d exp=%0d", i, lat, exp_er ? 1 : LAT+1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    logic exp_er;
    int pulses[3];
    int np;
    int cyc;
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, exp_rd, exp_er);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10; wdata = 32'd0;
    np = 0; cyc = 0;
    while (np < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        pulses[np] = cyc;
        np++;
        total++; if (rdata !== exp_rd) begin bad++; $display("FAIL b2b_rdata: got=%h exp=%h", rdata, exp_rd); end
      end
    end
    req = 1'b0;
    total++; if (np != 3) begin bad++; $display("FAIL b2b_pulses: got=%0d exp=3", np); end
    if (np == 3) begin
      total++; if (pulses[1] - pulses[0] != LAT+2) begin bad++; $display("FAIL b2b_gap1: got=%0d exp=%0d", pulses[1]-pulses[0], LAT+2); end
      total++; if (pulses[2] - pulses[1] != LAT+2) begin bad++; $display("FAIL b2b_gap2: got=%0d exp=%0d", pulses[2]-pulses[1], LAT+2); end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    last_rd = 32'd0;
    test_reset();
    init_mem();
    test_subword();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
